// File: rtl/lzrw1_pkg.sv
// Shared constants and state encoding for the LZRW1 decompressor feed path.
// State codes are plain localparams; the enum mirrors them for debug visibility.
package lzrw1_pkg;

  localparam int ITEM_W       = 16;
  localparam int CW_W         = 8;
  localparam int ITEMS_PER_CW = 8;
  localparam int IDX_W        = $clog2(ITEMS_PER_CW);
  localparam int CNT_W        = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_CW   = 3'd1;
  localparam logic [2:0] ST_GET_ITEM = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI  = 3'd4;
  localparam logic [2:0] ST_WAIT_LO  = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    GET_CW   = ST_GET_CW,
    GET_ITEM = ST_GET_ITEM,
    ISSUE    = ST_ISSUE,
    WAIT_HI  = ST_WAIT_HI,
    WAIT_LO  = ST_WAIT_LO,
    DONE     = ST_DONE
  } state_t;

endpackage

// File: rtl/lzrw1_cw_shifter.sv
// Control-byte shifter: presents the MSB-first control bit for the current item
// together with the item index inside the group.
module lzrw1_cw_shifter
  import lzrw1_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [CW_W-1:0]  cw,
  output logic             cw_bit,
  output logic [IDX_W-1:0] index
);

  logic [CW_W-1:0] cw_reg;
  logic [IDX_W-1:0] idx_reg;

  // Load wins over shift; the index wraps naturally after the last item.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cw_reg  <= '0;
      idx_reg <= '0;
    end else if (load) begin
      cw_reg  <= cw;
      idx_reg <= '0;
    end else if (shift) begin
      cw_reg  <= {cw_reg[CW_W-2:0], 1'b0};
      idx_reg <= idx_reg + 1'b1;
    end
  end

  assign cw_bit = cw_reg[CW_W-1];
  assign index  = idx_reg;

endmodule

// File: rtl/decompressor_feed_ctrl.sv
// Feeds control bytes and compressed items to an LZRW1 decompressor, one item
// at a time, pacing each issue on the decompressor's busy handshake.
module decompressor_feed_ctrl
  import lzrw1_pkg::*;
#(
  parameter int MAX_ITEMS = 4096,
  parameter int BUSY_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ITEM_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [ITEM_W-1:0] data_in,
  output logic              control_word_in,
  output logic              data_in_valid,
  input  logic              decompressor_busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  items_issued
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_ITEMS);
  localparam logic [7:0]       WAIT_LAST = 8'(BUSY_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ITEMS_PER_CW - 1);

  logic [2:0]        state_reg, state_next;
  logic [ITEM_W-1:0] data_reg;
  logic              ctrl_reg;
  logic              last_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [7:0]        wait_reg;

  logic             xfer;
  logic             issue;
  logic             hi_timeout;
  logic             item_done;
  logic             cap_hit;
  logic             cw_load;
  logic             cw_bit;
  logic [IDX_W-1:0] cw_index;
  logic [2:0]       after_item;

  assign in_ready   = (state_reg == ST_GET_CW) || (state_reg == ST_GET_ITEM);
  assign xfer       = in_valid && in_ready;
  assign issue      = (state_reg == ST_ISSUE) && !decompressor_busy;
  // Busy never rose within the window: the decompressor took the item in zero cycles.
  assign hi_timeout = (state_reg == ST_WAIT_HI) && !decompressor_busy && (wait_reg == WAIT_LAST);
  assign item_done  = ((state_reg == ST_WAIT_LO) && !decompressor_busy) || hi_timeout;
  assign cap_hit    = (issued_reg == MAX_CNT);
  assign cw_load    = (state_reg == ST_GET_CW) && xfer;

  lzrw1_cw_shifter u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (cw_load),
    .shift   (item_done),
    .cw      (in_word[CW_W-1:0]),
    .cw_bit  (cw_bit),
    .index   (cw_index)
  );

  always_comb begin
    after_item = ST_GET_ITEM;
    if (last_reg || cap_hit) begin
      after_item = ST_DONE;
    end else if (cw_index == LAST_IDX) begin
      after_item = ST_GET_CW;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start) state_next = ST_GET_CW;
      ST_GET_CW:   if (xfer) state_next = in_last ? ST_DONE : ST_GET_ITEM;
      ST_GET_ITEM: if (xfer) state_next = ST_ISSUE;
      ST_ISSUE:    if (!decompressor_busy) state_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (decompressor_busy) state_next = ST_WAIT_LO;
        else if (hi_timeout)   state_next = after_item;
      end
      ST_WAIT_LO:  if (!decompressor_busy) state_next = after_item;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      data_reg   <= '0;
      ctrl_reg   <= 1'b0;
      last_reg   <= 1'b0;
      err_reg    <= 1'b0;
      issued_reg <= '0;
      wait_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) && start) begin
        err_reg    <= 1'b0;
        issued_reg <= '0;
      end
      if ((state_reg == ST_GET_ITEM) && xfer) begin
        data_reg <= in_word;
        ctrl_reg <= cw_bit;
        last_reg <= in_last;
      end
      if (issue) issued_reg <= issued_reg + 1'b1;
      if (item_done && !last_reg && cap_hit) err_reg <= 1'b1;
      if (state_reg != ST_WAIT_HI)    wait_reg <= '0;
      else if (!decompressor_busy)    wait_reg <= wait_reg + 1'b1;
    end
  end

  assign data_in         = data_reg;
  assign control_word_in = ctrl_reg;
  assign data_in_valid   = issue;
  assign done            = (state_reg == ST_DONE);
  assign err             = err_reg;
  assign items_issued    = issued_reg;

endmodule

// File: tb/tb_decompressor_feed_ctrl.sv
// Directed bench for decompressor_feed_ctrl with a busy-pulse decompressor model
// and a scoreboard of expected {control bit, item} issues.
module tb_decompressor_feed_ctrl;

  logic        clock;
  logic        reset_n;

  logic        start, in_valid, in_last, in_ready;
  logic [15:0] in_word, data_in, items_issued;
  logic        control_word_in, data_in_valid, busy, done, err;

  logic        start_s, in_valid_s, in_last_s, in_ready_s;
  logic [15:0] in_word_s, data_in_s, items_issued_s;
  logic        control_word_in_s, data_in_valid_s, busy_s, done_s, err_s;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int busy_len = 1;
  int busy_cnt;
  logic force_busy;
  logic [16:0] exp_q[$];

  decompressor_feed_ctrl u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_word(in_word),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .data_in(data_in), .control_word_in(control_word_in),
    .data_in_valid(data_in_valid), .decompressor_busy(busy),
    .done(done), .err(err), .items_issued(items_issued)
  );

  decompressor_feed_ctrl #(.MAX_ITEMS(4), .BUSY_WAIT(2)) u_dut_small (
    .clock(clock), .reset_n(reset_n), .start(start_s), .in_word(in_word_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_last(in_last_s),
    .data_in(data_in_s), .control_word_in(control_word_in_s),
    .data_in_valid(data_in_valid_s), .decompressor_busy(busy_s),
    .done(done_s), .err(err_s), .items_issued(items_issued_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decompressor model: busy rises the cycle after a strobe and lasts busy_len cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_cnt <= 0;
    else if (data_in_valid) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign busy   = force_busy || (busy_cnt != 0);
  assign busy_s = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (data_in_valid) begin
      logic [16:0] e;
      strobe_cnt++;
      check("no_strobe_while_busy", busy, 0);
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("[TB] issue data=0x%04h ctrl=%0d (exp data=0x%04h ctrl=%0d)",
                 data_in, control_word_in, e[15:0], e[16]);
        check("issue_data", data_in, e[15:0]);
        check("issue_ctrl", control_word_in, e[16]);
      end
    end
  end

  task automatic pulse_start(input bit sel);
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    start   = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [15:0] word, input bit last,
                      input bit is_item, input bit ctrl, input bit chk_lat);
    int n = 0;
    if (sel) begin in_word_s = word; in_last_s = last; in_valid_s = 1'b1; end
    else     begin in_word   = word; in_last   = last; in_valid   = 1'b1; end
    while (((sel ? in_ready_s : in_ready) !== 1'b1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("send_ready_timeout", sel ? in_ready_s : in_ready, 1);
    if (is_item && !sel) exp_q.push_back({ctrl, word});
    @(negedge clock);
    in_valid_s = 1'b0;
    in_valid   = 1'b0;
    if (chk_lat) check("issue_latency", sel ? data_in_valid_s : data_in_valid, 1);
  endtask

  task automatic stream(input logic [7:0] cw, input int n, input logic [15:0] base,
                        input bit last_at_end, input bit chk_lat);
    logic [7:0] c;
    c = cw;
    send(0, {8'h00, cw}, 0, 0, 0, 0);
    for (int i = 0; i < n; i++)
      send(0, base + 16'(i), last_at_end && (i == n - 1), 1, c[7 - i], chk_lat);
  endtask

  task automatic wait_done(input bit sel, input string tag);
    int n = 0;
    while (((sel ? done_s : done) !== 1'b1) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, sel ? done_s : done, 1);
    @(negedge clock);
    check("done_one_cycle", sel ? done_s : done, 0);
  endtask

  initial begin
    int s0, d0;
    logic seen;
    reset_n = 1'b0; force_busy = 1'b0;
    start = 0; in_valid = 0; in_last = 0; in_word = '0;
    start_s = 0; in_valid_s = 0; in_last_s = 0; in_word_s = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", data_in_valid, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_items", items_issued, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Eight literals under control byte 0x00.
    busy_len = 1;
    pulse_start(0);
    s0 = strobe_cnt;
    stream(8'h00, 8, 16'h0041, 1, 1);
    wait_done(0, "lit8_done");
    check("lit8_items", items_issued, 8);
    check("lit8_strobes", strobe_cnt - s0, 8);
    check("lit8_err", err, 0);

    // Mixed control bits 1,0,1 from 0xA0.
    pulse_start(0);
    stream(8'hA0, 3, 16'h0200, 1, 1);
    wait_done(0, "mix3_done");
    check("mix3_items", items_issued, 3);

    // Two groups with the fast path (busy never rises).
    busy_len = 0;
    pulse_start(0);
    stream(8'hFF, 8, 16'h1000, 0, 1);
    stream(8'h01, 8, 16'h2000, 1, 1);
    wait_done(0, "wrap16_done");
    check("wrap16_items", items_issued, 16);
    busy_len = 1;

    // Busy held high before the issue.
    pulse_start(0);
    send(0, 16'h0080, 0, 0, 0, 0);
    force_busy = 1'b1;
    s0 = strobe_cnt;
    send(0, 16'h1234, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_no_strobe", data_in_valid, 0);
      @(negedge clock);
    end
    @(posedge clock);
    #1 force_busy = 1'b0;
    @(negedge clock);
    check("hold_strobe_after_fall", data_in_valid, 1);
    wait_done(0, "hold_done");
    check("hold_one_strobe", strobe_cnt - s0, 1);

    // Reset asserted in WAIT_LO of the third item.
    busy_len = 4;
    pulse_start(0);
    stream(8'h00, 3, 16'h3000, 0, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready_valid", {in_ready, data_in_valid}, 0);
    check("mid_rst_done_err", {done, err}, 0);
    check("mid_rst_data", {control_word_in, data_in}, 0);
    check("mid_rst_items", items_issued, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    s0 = strobe_cnt; d0 = done_cnt;
    repeat (10) @(negedge clock);
    check("post_rst_no_strobe", strobe_cnt - s0, 0);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_idle", in_ready, 0);
    pulse_start(0);
    check("post_rst_start", in_ready, 1);

    // MAX_ITEMS=4 instance: stream without in_last is cut off with err.
    pulse_start(1);
    send(1, 16'h0000, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) send(1, 16'h0100 + 16'(i), 0, 1, 0, 1);
    wait_done(1, "cap_done");
    check("cap_err", err_s, 1);
    check("cap_items", items_issued_s, 4);
    in_word_s = 16'h0105; in_valid_s = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen = seen | in_ready_s;
    end
    in_valid_s = 1'b0;
    check("cap_no_ready", seen, 0);
    check("cap_err_sticky", err_s, 1);
    pulse_start(1);
    check("cap_err_cleared", err_s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decompressor_feed_ctrl.md
DECOMPRESSOR_FEED_CTRL -- requirements
Module: decompressor_feed_ctrl

Interface
REQ-001 SHALL have parameter MAX_ITEMS, 4096, maximum items accepted per stream; larger streams are terminated with err.
REQ-002 SHALL have parameter BUSY_WAIT, 2, cycles allowed after issue for decompressor_busy to rise.
REQ-003 SHALL have port clock  in  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse in IDLE that begins a stream.
REQ-006 SHALL have port in_word  in  16  upstream word: the control byte in [7:0] when in GET_CW, otherwise a compressed item.
REQ-007 SHALL have ports in_valid  in  1, in_ready  out  1, in_last  in  1; in_last marks the final word of the stream.
REQ-008 SHALL have port data_in  out  16  item to the decompressor.
REQ-009 SHALL have port control_word_in  out  1  control bit for data_in: 1 = copy item, 0 = literal item.
REQ-010 SHALL have port data_in_valid  out  1  one-cycle issue strobe.
REQ-011 SHALL have port decompressor_busy  in  1  high while the decompressor processes an item.
REQ-012 SHALL have ports done  out  1 (one-cycle pulse), err  out  1 (sticky until next start), items_issued  out  16.

Function
REQ-013 SHALL implement the states IDLE, GET_CW, GET_ITEM, ISSUE, WAIT_HI, WAIT_LO and DONE.
REQ-014 IDLE SHALL move to GET_CW on start; start SHALL be ignored in every other state.
REQ-015 in_ready SHALL be 1 only in GET_CW and GET_ITEM; a word transfers when in_valid && in_ready.
REQ-016 GET_CW transfer SHALL load in_word[7:0] into the control shifter, clear the item index and go to GET_ITEM; in_last on a control word SHALL go to DONE with no issue.
REQ-017 GET_ITEM transfer SHALL register the word and the current control bit, taking bits MSB first (item 0 uses bit 7), then go to ISSUE.
REQ-018 ISSUE SHALL hold while decompressor_busy=1; when busy=0 it SHALL assert data_in_valid for exactly one cycle, increment items_issued and go to WAIT_HI.
REQ-019 data_in and control_word_in SHALL stay stable from ISSUE until the next GET_ITEM transfer.
REQ-020 WAIT_HI SHALL go to WAIT_LO when busy=1; if busy stays 0 for BUSY_WAIT cycles, the item SHALL be treated as complete (literal fast path).
REQ-021 WAIT_LO SHALL wait for busy=0, then go to DONE if the item carried in_last.
REQ-022 Otherwise WAIT_LO SHALL go to GET_CW if the item index was 7 (wrap to 0), else to GET_ITEM with the index incremented.
REQ-023 When items_issued reaches MAX_ITEMS without in_last, the block SHALL set err and go to DONE.
REQ-024 DONE SHALL pulse done for one cycle and return to IDLE; err SHALL clear on the next accepted start.
REQ-025 data_in_valid SHALL never be asserted in a cycle where decompressor_busy=1.
REQ-026 Output latency SHALL be: GET_ITEM transfer to data_in_valid = 1 cycle when the decompressor is idle.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE and force in_ready, data_in_valid, done and err to 0.
REQ-028 reset_n low SHALL also clear data_in, control_word_in, items_issued, the shifter and the index to 0.
REQ-029 Reset asserted mid-stream SHALL abandon the stream, with no done pulse and no further issue after release.

Structure
REQ-030 Package lzrw1_pkg SHALL hold the state enum, ITEMS_PER_CW=8 and the item/control-word width constants.
REQ-031 The single sub-module lzrw1_cw_shifter SHALL be used: an 8-bit load/shift register presenting the MSB-first control bit and the 3-bit index.

Verification
REQ-032 Control byte 0x00 followed by 8 literals 0x0041..0x0048 (last on the 8th), busy high for 1 cycle per item -> 8 strobes with control_word_in=0, items_issued=8, done pulse.
REQ-033 Control byte 0xA0 followed by 3 items, in_last on item 3 -> control bits 1,0,1; done after the third busy fall; items_issued=3.
REQ-034 Busy held high for 5 cycles before an issue -> data_in_valid stays low until busy falls, then strobes once; no strobe while busy=1.
REQ-035 16 items over two control bytes, 0xFF then 0x01 -> the wrap returns to GET_CW after item 8; second-group control bits are 0 x7 then 1.
REQ-036 MAX_ITEMS=4 with 6 items and no in_last -> err=1 and done after the 4th item; in_ready=0 afterwards.
REQ-037 reset_n pulsed low during WAIT_LO of item 3 -> all outputs 0 immediately; after release the block sits in IDLE until start.
